// File: rtl/seller_pkg.sv
// Shared types and constants for the vending-machine transaction controller.
//   state_e  : controller states (idle, collecting coins, vend pulse, refund pulse)
//   VAL_HALF : credit value of a 0.5-yuan coin, in half-yuan units
//   VAL_ONE  : credit value of a 1-yuan coin, in half-yuan units
package seller_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StVend,
    StRefund
  } state_e;

  localparam logic [1:0] VAL_HALF = 2'd1;
  localparam logic [1:0] VAL_ONE  = 2'd2;

endpackage

// File: rtl/seller_ctrl.sv
// Vending-machine transaction controller. Accumulates coin credit, arms the
// external timer while collecting, treats the timer's t_end as an inactivity
// timeout, and issues vend / change / refund / reject pulses. All outputs are
// registered.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   coin_half    : 0.5-yuan coin pulse (value 1)
//   coin_one     : 1-yuan coin pulse (value 2)
//   cancel       : user abort pulse
//   t_end        : timeout from the timer
//   t_rst_n      : timer enable, 0 = counting, 1 = paused
//   goods_out    : vend pulse
//   refund_out   : refund pulse
//   change_valid : change_out qualifier pulse
//   change_out   : change or refund amount in half-yuan units, 0 when not valid
//   coin_reject  : coin arrived while vending or refunding
module seller_ctrl
  import seller_pkg::*;
#(
  parameter int unsigned PRICE = 5,
  parameter int unsigned CW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_half,
  input  logic          coin_one,
  input  logic          cancel,
  input  logic          t_end,
  output logic          t_rst_n,
  output logic          goods_out,
  output logic          refund_out,
  output logic          change_valid,
  output logic [CW-1:0] change_out,
  output logic          coin_reject
);

  localparam logic [CW-1:0] PriceW  = CW'(PRICE);
  localparam logic [CW-1:0] MaxChg  = CW'(2);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          first_q, first_d;

  logic [1:0]    coin_val;
  logic [CW-1:0] coin_ext;
  logic [CW-1:0] sum;
  logic [CW-1:0] change;

  logic          t_rst_n_q, t_rst_n_d;
  logic          goods_q, goods_d;
  logic          refund_q, refund_d;
  logic          chg_valid_q, chg_valid_d;
  logic [CW-1:0] chg_out_q, chg_out_d;
  logic          reject_q, reject_d;

  assign coin_val = (coin_half ? VAL_HALF : 2'd0) + (coin_one ? VAL_ONE : 2'd0);
  assign coin_ext = CW'(coin_val);
  assign sum      = credit_q + coin_ext;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      credit_q    <= '0;
      first_q     <= 1'b0;
      t_rst_n_q   <= 1'b1;
      goods_q     <= 1'b0;
      refund_q    <= 1'b0;
      chg_valid_q <= 1'b0;
      chg_out_q   <= '0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      first_q     <= first_d;
      t_rst_n_q   <= t_rst_n_d;
      goods_q     <= goods_d;
      refund_q    <= refund_d;
      chg_valid_q <= chg_valid_d;
      chg_out_q   <= chg_out_d;
      reject_q    <= reject_d;
    end
  end

  // Next state and credit.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    unique case (state_q)
      StIdle: begin
        credit_d = coin_ext;
        if (coin_val != 2'd0) begin
          state_d = (coin_ext >= PriceW) ? StVend : StCollect;
        end
      end
      StCollect: begin
        credit_d = sum;
        if (sum >= PriceW) begin
          state_d = StVend;
        end else if (cancel) begin
          state_d = StRefund;
        end else if (t_end && !first_q) begin
          // first_q masks a stale t_end the paused timer may still be holding
          state_d = StRefund;
        end
      end
      StVend, StRefund: begin
        state_d  = StIdle;
        credit_d = '0;
      end
      default: begin
        state_d  = StIdle;
        credit_d = '0;
      end
    endcase
    first_d = (state_d == StCollect) && (state_q != StCollect);
  end

  // Output next values, derived from the state being entered so that each
  // pulse appears one cycle after the causing input.
  always_comb begin
    change      = credit_d - PriceW;
    if (change > MaxChg) begin
      change = MaxChg;
    end
    t_rst_n_d   = (state_d != StCollect);
    goods_d     = (state_d == StVend);
    refund_d    = (state_d == StRefund);
    chg_valid_d = 1'b0;
    chg_out_d   = '0;
    if (state_d == StVend && change != '0) begin
      chg_valid_d = 1'b1;
      chg_out_d   = change;
    end else if (state_d == StRefund) begin
      chg_valid_d = 1'b1;
      chg_out_d   = credit_d;
    end
    reject_d    = ((state_q == StVend) || (state_q == StRefund)) && (coin_val != 2'd0);
  end

  assign t_rst_n      = t_rst_n_q;
  assign goods_out    = goods_q;
  assign refund_out   = refund_q;
  assign change_valid = chg_valid_q;
  assign change_out   = chg_out_q;
  assign coin_reject  = reject_q;

endmodule

// File: tb/tb_seller_ctrl.sv
// Scoreboard bench for seller_ctrl (PRICE = 5). Stimulus pushes the expected
// output pulse set plus its expected cycle; a monitor pops one entry whenever
// any output pulse is visible and compares it.
module tb_seller_ctrl;

  logic       clk;
  logic       rst;
  logic       coin_half, coin_one, cancel, t_end;
  logic       t_rst_n, goods_out, refund_out, change_valid, coin_reject;
  logic [5:0] change_out;

  typedef struct {
    logic       goods;
    logic       refund;
    logic       cv;
    logic [5:0] co;
    logic       rej;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   vectors;
  int   miscompares;

  seller_ctrl #(
    .PRICE(5),
    .CW   (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_half   (coin_half),
    .coin_one    (coin_one),
    .cancel      (cancel),
    .t_end       (t_end),
    .t_rst_n     (t_rst_n),
    .goods_out   (goods_out),
    .refund_out  (refund_out),
    .change_valid(change_valid),
    .change_out  (change_out),
    .coin_reject (coin_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Wait for the next negedge, check t_rst_n as left by the previous cycle,
  // then apply this cycle's inputs.
  task automatic step(input logic h, input logic o, input logic c, input logic t,
                      input logic exp_trst);
    @(negedge clk);
    chk("t_rst_n", int'(t_rst_n), int'(exp_trst));
    coin_half = h;
    coin_one  = o;
    cancel    = c;
    t_end     = t;
  endtask

  // Expected pulse caused by the inputs applied in the current step.
  task automatic expect_out(input logic g, input logic r, input logic cv, input logic [5:0] co,
                            input logic rej);
    exp_t e;
    e.goods  = g;
    e.refund = r;
    e.cv     = cv;
    e.co     = co;
    e.rej    = rej;
    e.cyc    = cyc + 1;
    exp_q.push_back(e);
  endtask

  // Monitor: any visible pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (goods_out || refund_out || change_valid || coin_reject || change_out != 6'd0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got g=%0b r=%0b cv=%0b co=%0d rej=%0b, expected none (cycle %0d)",
                 goods_out, refund_out, change_valid, change_out, coin_reject, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (goods_out !== e.goods || refund_out !== e.refund || change_valid !== e.cv ||
            change_out !== e.co || coin_reject !== e.rej || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL pulse: got g=%0b r=%0b cv=%0b co=%0d rej=%0b cyc=%0d, expected g=%0b r=%0b cv=%0b co=%0d rej=%0b cyc=%0d",
                   goods_out, refund_out, change_valid, change_out, coin_reject, cyc,
                   e.goods, e.refund, e.cv, e.co, e.rej, e.cyc);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    coin_half   = 1'b0;
    coin_one    = 1'b0;
    cancel      = 1'b0;
    t_end       = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_t_rst_n", int'(t_rst_n), 1);
    chk("rst_goods", int'(goods_out), 0);
    chk("rst_refund", int'(refund_out), 0);
    chk("rst_change_valid", int'(change_valid), 0);
    chk("rst_change_out", int'(change_out), 0);
    chk("rst_reject", int'(coin_reject), 0);

    // 1. Exact payment 2+2+1
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_out(1, 0, 0, 6'd0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // 2. Overpay: 2+2, then half+one together -> 7, change 2
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    expect_out(1, 0, 1, 6'd2, 0);
    step(0, 0, 0, 0, 1);

    // 3. Cancel with a coin in the same cycle: 2, then cancel + half -> refund 3
    step(0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0);
    expect_out(0, 1, 1, 6'd3, 0);
    step(0, 0, 0, 0, 1);

    // 4. Timeout: t_end ignored in IDLE and masked on first COLLECT cycle
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    expect_out(0, 1, 1, 6'd1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // 5a. Coin during VEND is rejected and not credited
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_out(1, 0, 0, 6'd0, 0);
    step(0, 1, 0, 0, 1);
    expect_out(0, 0, 0, 6'd0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    expect_out(0, 1, 1, 6'd1, 0);
    // Coin during REFUND is rejected too
    step(1, 0, 0, 0, 1);
    expect_out(0, 0, 0, 6'd0, 1);
    step(0, 0, 0, 0, 1);

    // 5b. Credit 4, coin_one with cancel -> vend wins, change 1
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    expect_out(1, 0, 1, 6'd1, 0);
    step(0, 0, 0, 0, 1);

    // 6. Reset mid-transaction at credit 3, then fresh credit
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_t_rst_n", int'(t_rst_n), 1);
    chk("rst_mid_refund", int'(refund_out), 0);
    chk("rst_mid_change_valid", int'(change_valid), 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_out(1, 0, 0, 6'd0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
